// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter.
// The master drives the step controls and the bound configuration. The slave is the counter,
// which returns the count and its status flags.
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] limit;
  logic             sat_mode;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             wrap;

  modport master (
    output enable, up_down, load, load_value, limit, sat_mode,
    input  count, at_max, at_min, wrap
  );

  modport slave (
    input  enable, up_down, load, load_value, limit, sat_mode,
    output count, at_max, at_min, wrap
  );
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with a runtime inclusive upper limit.
// Each edge it applies one of reset, load, enable-step or hold, in that priority order.
// At the 0 and limit bounds it either wraps or saturates.
// wrap is a registered one-cycle pulse marking an edge whose step crossed a bound.
// at_max and at_min are same-cycle decodes of the registered count.
module param_updown_counter #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  param_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] count_p0;
  logic             wrap_p0;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // Saturate a loaded value into the legal range 0..limit.
  function automatic logic [WIDTH-1:0] clamp_to_limit(
    input logic [WIDTH-1:0] value,
    input logic [WIDTH-1:0] lim
  );
    return (value > lim) ? lim : value;
  endfunction

  // Upward step. At the limit it wraps to 0 (flagging the crossing) or holds when saturating.
  function automatic logic [WIDTH:0] step_up(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] lim,
    input logic             sat
  );
    logic [WIDTH-1:0] nxt;
    logic             crossed;
    nxt     = cur + ONE;
    crossed = 1'b0;
    if (cur == lim) begin
      nxt     = sat ? lim : ZERO;
      crossed = ~sat;
    end
    return {crossed, nxt};
  endfunction

  // Downward step. At 0 it wraps to the limit (flagging the crossing) or holds when saturating.
  function automatic logic [WIDTH:0] step_down(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] lim,
    input logic             sat
  );
    logic [WIDTH-1:0] nxt;
    logic             crossed;
    nxt     = cur - ONE;
    crossed = 1'b0;
    if (cur == ZERO) begin
      nxt     = sat ? ZERO : lim;
      crossed = ~sat;
    end
    return {crossed, nxt};
  endfunction

  // Next-state selection: load beats enable, enable beats hold; wrap defaults low.
  // A count left above a lowered limit snaps to the limit on the next enabled step.
  always_comb begin
    count_nxt = count_p0;
    wrap_nxt  = 1'b0;
    if (bus.load) begin
      count_nxt = clamp_to_limit(bus.load_value, bus.limit);
    end else if (bus.enable) begin
      if (count_p0 > bus.limit) begin
        count_nxt = bus.limit;
      end else if (bus.up_down) begin
        {wrap_nxt, count_nxt} = step_up(count_p0, bus.limit, bus.sat_mode);
      end else begin
        {wrap_nxt, count_nxt} = step_down(count_p0, bus.limit, bus.sat_mode);
      end
    end
  end

  // ---- stage p0: registered count and wrap pulse ----
  // Count register with synchronous reset that overrides all other inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_p0 <= RESET_VALUE;
      wrap_p0  <= 1'b0;
    end else begin
      count_p0 <= count_nxt;
      wrap_p0  <= wrap_nxt;
    end
  end

  assign bus.count  = count_p0;
  assign bus.wrap   = wrap_p0;
  assign bus.at_max = (count_p0 == bus.limit);
  assign bus.at_min = (count_p0 == ZERO);

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter (WIDTH=4, RESET_VALUE=0).
// A table of per-edge vectors, each holding inputs plus expected outputs, is applied in order.
// Expectations are queued when a vector is driven and popped when the edge result is sampled.
module tb_param_updown_counter;
  localparam int W = 4;

  typedef struct {
    logic         rst;
    logic         en;
    logic         ud;
    logic         ld;
    logic [W-1:0] lv;
    logic [W-1:0] lim;
    logic         sat;
    logic [W-1:0] exp_count;
    logic         exp_wrap;
    logic         exp_max;
    logic         exp_min;
  } vec_t;

  typedef struct {
    int           idx;
    logic [W-1:0] cnt;
    logic         wr;
    logic         mx;
    logic         mn;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clock = ~clock;

  param_updown_counter_if #(.WIDTH(W)) bus ();

  param_updown_counter #(.WIDTH(W), .RESET_VALUE(0)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  function automatic vec_t mk(input logic rst, input logic en, input logic ud, input logic ld,
                              input int lv, input int lim, input logic sat,
                              input int ec, input logic ew, input logic emx, input logic emn);
    vec_t v;
    v.rst = rst; v.en = en; v.ud = ud; v.ld = ld;
    v.lv = W'(lv); v.lim = W'(lim); v.sat = sat;
    v.exp_count = W'(ec); v.exp_wrap = ew; v.exp_max = emx; v.exp_min = emn;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, got, want);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    @(negedge clock);
    reset          = v.rst;
    bus.enable     = v.en;
    bus.up_down    = v.ud;
    bus.load       = v.ld;
    bus.load_value = v.lv;
    bus.limit      = v.lim;
    bus.sat_mode   = v.sat;
    e.idx = idx; e.cnt = v.exp_count; e.wr = v.exp_wrap; e.mx = v.exp_max; e.mn = v.exp_min;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty vec=%0d got=0 want=1", idx);
    end else begin
      e = sb.pop_front();
      cmp("count",  e.idx, int'(bus.count),  int'(e.cnt));
      cmp("wrap",   e.idx, int'(bus.wrap),   int'(e.wr));
      cmp("at_max", e.idx, int'(bus.at_max), int'(e.mx));
      cmp("at_min", e.idx, int'(bus.at_min), int'(e.mn));
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    reset = 1'b1;
    bus.enable = 1'b0; bus.up_down = 1'b0; bus.load = 1'b0;
    bus.load_value = '0; bus.limit = 4'd15; bus.sat_mode = 1'b0;

    // Reset for two edges, then free-running up count with binary wrap.
    tbl.push_back(mk(1, 0, 0, 0, 0, 15, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 15, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 18; k++) begin
      c = k % 16;
      tbl.push_back(mk(0, 1, 1, 0, 0, 15, 0, c, k == 16, c == 15, c == 0));
    end
    // Modulo-10 down count from 0: 9,8..0,9 with wrap after each 0->9.
    tbl.push_back(mk(0, 0, 0, 1, 0, 9, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 11; k++) begin
      c = ((10 - k) % 10 + 10) % 10;
      tbl.push_back(mk(0, 1, 0, 0, 0, 9, 0, c, (k == 1) || (k == 11), c == 9, c == 0));
    end
    // Saturating up from 7 and down from 1.
    tbl.push_back(mk(0, 0, 0, 1, 7, 9, 1, 7, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 9, 1, 8, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 9, 1, 9, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 9, 1, 9, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 9, 1, 9, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 9, 1, 9, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 9, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 9, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 9, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 9, 1, 0, 0, 0, 1));
    // Load beats enable and clamps to limit.
    tbl.push_back(mk(0, 1, 1, 1, 12, 9, 0, 9, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 3, 9, 0, 3, 0, 0, 0));
    // Limit lowered under a stale count: hold while disabled, snap on next step.
    tbl.push_back(mk(0, 0, 0, 1, 12, 15, 0, 12, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0, 12, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0, 12, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 5, 0, 5, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 12, 15, 1, 12, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 5, 1, 5, 0, 1, 0));
    // limit==0: stale count snaps to 0, then every enabled wrap-mode step pulses wrap.
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    // Reset mid-run with enable high, then resume; reset also beats load.
    tbl.push_back(mk(0, 0, 0, 1, 5, 15, 0, 5, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 15, 0, 6, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 15, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 15, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 15, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 7, 15, 0, 0, 0, 0, 1));

    foreach (tbl[i]) apply(i, tbl[i]);

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
